popcnt_frame_accum: RTL

//   Downstream consumer of the 8-bit ones counter (onectr). Accepts a byte stream framed
//   by in_last over a valid/ready handshake. Counts the set bits in each byte and adds

---
 rtl/popcnt_frame_accum.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/popcnt_frame_accum.sv
// popcnt_frame_accum
//   Accepts a byte stream framed by in_last over a valid/ready handshake, counts
//   the set bits of every byte and accumulates them across the frame. The frame
//   total, the number of bytes and a sticky saturation flag are presented on a
//   held, registered output with a valid/ready handshake.
//
// Parameters
//   CNT_W  width of frame ones total, saturating at 2^CNT_W-1 (CNT_W >= 4)
//   LEN_W  width of frame byte counter, saturating at 2^LEN_W-1 (LEN_W >= 1)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   in_data/in_last valid
//   in_ready   block can accept a byte (low only while a result is held)
//   in_data    data byte
//   in_last    byte is the final byte of the frame
//   out_valid  frame result available
//   out_ready  consumer takes the result
//   out_count  total set bits in the frame
//   out_bytes  number of bytes in the frame
//   out_sat    out_count or out_bytes saturated during the frame
module popcnt_frame_accum #(
    parameter int unsigned CNT_W = 12,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic [LEN_W-1:0] out_bytes,
    output logic             out_sat
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [CNT_W-1:0] r_acc;
    logic [LEN_W-1:0] r_nbytes;
    logic             r_sat;

    logic [CNT_W-1:0] w_acc_nxt;
    logic [LEN_W-1:0] w_nbytes_nxt;
    logic             w_sat_nxt;

    logic             r_out_valid;
    logic [CNT_W-1:0] r_out_count;
    logic [LEN_W-1:0] r_out_bytes;
    logic             r_out_sat;

    logic             w_beat;
    logic [3:0]       w_pc;

    // Sums are one bit wider than the registers so the carry flags overflow.
    logic [CNT_W:0]   w_acc_sum;
    logic [LEN_W:0]   w_len_sum;
    logic [CNT_W-1:0] w_acc_clamp;
    logic [LEN_W-1:0] w_len_clamp;

    // Set-bit count of the incoming byte, range 0..8.
    always_comb begin
        w_pc = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            w_pc = w_pc + {3'b000, in_data[i]};
        end
    end

    assign in_ready = (r_state != HOLD);
    assign w_beat   = in_valid & in_ready;

    assign w_acc_sum   = {1'b0, r_acc} + (CNT_W + 1)'(w_pc);
    assign w_len_sum   = {1'b0, r_nbytes} + (LEN_W + 1)'(1);
    assign w_acc_clamp = w_acc_sum[CNT_W] ? '1 : w_acc_sum[CNT_W-1:0];
    assign w_len_clamp = w_len_sum[LEN_W] ? '1 : w_len_sum[LEN_W-1:0];

    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_nbytes_nxt = r_nbytes;
        w_sat_nxt    = r_sat;
        case (r_state)
            IDLE: begin
                if (w_beat) begin
                    w_acc_nxt    = CNT_W'(w_pc);
                    w_nbytes_nxt = LEN_W'(1);
                    w_sat_nxt    = 1'b0;
                    w_state_nxt  = in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (w_beat) begin
                    w_acc_nxt    = w_acc_clamp;
                    w_nbytes_nxt = w_len_clamp;
                    w_sat_nxt    = r_sat | w_acc_sum[CNT_W] | w_len_sum[LEN_W];
                    if (in_last) begin
                        w_state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_nbytes <= '0;
            r_sat    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_acc    <= w_acc_nxt;
            r_nbytes <= w_nbytes_nxt;
            r_sat    <= w_sat_nxt;
        end
    end

    // Result registers load only on the transition into HOLD, so they keep the
    // previous frame's result after release until the next frame completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_count <= '0;
            r_out_bytes <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            r_out_valid <= (w_state_nxt == HOLD);
            if ((w_state_nxt == HOLD) && (r_state != HOLD)) begin
                r_out_count <= w_acc_nxt;
                r_out_bytes <= w_nbytes_nxt;
                r_out_sat   <= w_sat_nxt;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_count = r_out_count;
    assign out_bytes = r_out_bytes;
    assign out_sat   = r_out_sat;

endmodule
